// File: rtl/pal_sync_decoder.sv
// rtl/pal_sync_decoder.sv - PAL composite sync slicer, pulse classifier and line/field lock
module pal_sync_decoder #(
   parameter logic [7:0] SYNC_LEVEL = 8'd40,
   parameter logic [7:0] HYST       = 8'd8,
   parameter int         EQ_MIN     = 80,
   parameter int         EQ_MAX     = 149,
   parameter int         HS_MIN     = 150,
   parameter int         HS_MAX     = 350,
   parameter int         BROAD_MIN  = 1000,
   parameter int         LINE_NOM   = 3200,
   parameter int         LINE_TOL   = 64,
   parameter int         LOCK_CNT   = 8
) (
   input  logic       clk50,
   input  logic       rst_n,
   input  logic [7:0] adc_data,
   output logic       hs_pulse,
   output logic       vs_pulse,
   output logic       field,
   output logic [9:0] line_count,
   output logic       locked
);

   localparam logic [8:0]  SYNC_ENTER  = {1'b0, SYNC_LEVEL};
   localparam logic [8:0]  SYNC_LEAVE  = {1'b0, SYNC_LEVEL} + {1'b0, HYST};
   localparam logic [11:0] EQ_MIN_W    = 12'(EQ_MIN);
   localparam logic [11:0] EQ_MAX_W    = 12'(EQ_MAX);
   localparam logic [11:0] HS_MIN_W    = 12'(HS_MIN);
   localparam logic [11:0] HS_MAX_W    = 12'(HS_MAX);
   localparam logic [11:0] BROAD_MIN_W = 12'(BROAD_MIN);
   localparam logic [12:0] PERIOD_LO   = 13'(LINE_NOM - LINE_TOL);
   localparam logic [12:0] PERIOD_HI   = 13'(LINE_NOM + LINE_TOL);
   localparam logic [12:0] SILENCE_MAX = 13'(2 * LINE_NOM);
   localparam logic [12:0] FIELD_SPLIT = 13'(LINE_NOM * 3 / 4);
   localparam logic [3:0]  GOOD_LAST   = 4'(LOCK_CNT - 1);

   typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCKED} state_t;

   state_t      state;
   logic        in_sync;
   logic        in_sync_d;
   logic [11:0] width;
   logic [12:0] period_tmr;
   logic [12:0] silence_tmr;
   logic [3:0]  good_cnt;
   logic [1:0]  broad_run;
   logic        field_pending;
   logic        last_eq;

   logic sync_fall;
   logic is_h;
   logic is_eq;
   logic is_broad;
   logic classified;
   logic period_ok;
   logic flywheel;
   logic vs_fire;

   // Pulse classification happens on the cycle the sliced sync level drops
   assign sync_fall  = in_sync_d & ~in_sync;
   assign is_h       = sync_fall && (width >= HS_MIN_W) && (width <= HS_MAX_W);
   assign is_eq      = sync_fall && (width >= EQ_MIN_W) && (width <= EQ_MAX_W);
   assign is_broad   = sync_fall && (width >= BROAD_MIN_W);
   assign classified = is_h | is_eq | is_broad;
   assign period_ok  = (period_tmr >= PERIOD_LO) && (period_tmr <= PERIOD_HI);
   assign flywheel   = (state == S_LOCKED) && !classified && (period_tmr >= PERIOD_HI);
   assign vs_fire    = is_broad && (broad_run == 2'd2) && (state == S_LOCKED);

   // Hysteresis slicer and sync-tip width measurement
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         in_sync   <= 1'b0;
         in_sync_d <= 1'b0;
         width     <= '0;
      end else begin
         if ({1'b0, adc_data} < SYNC_ENTER)
            in_sync <= 1'b1;
         else if ({1'b0, adc_data} > SYNC_LEAVE)
            in_sync <= 1'b0;
         in_sync_d <= in_sync;
         if (!in_sync)
            width <= '0;
         else if (width != 12'hFFF)
            width <= width + 12'd1;
      end
   end

   // Line period timer (restarted by the flywheel too) and silence timer
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         period_tmr  <= '0;
         silence_tmr <= '0;
      end else begin
         if (classified || flywheel)
            period_tmr <= '0;
         else if (period_tmr != 13'h1FFF)
            period_tmr <= period_tmr + 13'd1;
         if (classified)
            silence_tmr <= '0;
         else if (silence_tmr != 13'h1FFF)
            silence_tmr <= silence_tmr + 13'd1;
      end
   end

   // Lock FSM with strobes, field detection and line counter
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_SEARCH;
         good_cnt      <= '0;
         broad_run     <= '0;
         field_pending <= 1'b0;
         last_eq       <= 1'b0;
         hs_pulse      <= 1'b0;
         vs_pulse      <= 1'b0;
         field         <= 1'b0;
         line_count    <= '0;
         locked        <= 1'b0;
      end else begin
         hs_pulse <= is_h;
         vs_pulse <= vs_fire;

         case (state)
            S_SEARCH: begin
               if (is_h) begin
                  state    <= S_TRACK;
                  good_cnt <= '0;
               end
            end
            S_TRACK: begin
               if (is_h) begin
                  if (!period_ok) begin
                     good_cnt <= '0;
                  end else if (good_cnt == GOOD_LAST) begin
                     state    <= S_LOCKED;
                     locked   <= 1'b1;
                     good_cnt <= '0;
                  end else begin
                     good_cnt <= good_cnt + 4'd1;
                  end
               end else if (is_eq || is_broad) begin
                  state    <= S_SEARCH;
                  good_cnt <= '0;
               end
            end
            S_LOCKED: begin
               if (!classified && (silence_tmr >= SILENCE_MAX)) begin
                  state  <= S_SEARCH;
                  locked <= 1'b0;
               end
            end
            default: begin
               state  <= S_SEARCH;
               locked <= 1'b0;
            end
         endcase

         if (is_broad) begin
            if (broad_run != 2'd3)
               broad_run <= broad_run + 2'd1;
         end else if (is_h || is_eq) begin
            broad_run <= '0;
         end

         if (is_eq)
            last_eq <= 1'b1;
         else if (is_h || is_broad)
            last_eq <= 1'b0;

         // The first H after vsync decides the field from the EQ-to-H gap
         if (vs_fire) begin
            field_pending <= 1'b1;
         end else if (is_h && field_pending) begin
            field_pending <= 1'b0;
            if (last_eq)
               field <= (silence_tmr < FIELD_SPLIT);
         end

         if (vs_fire)
            line_count <= '0;
         else if ((is_h || flywheel) && (line_count != 10'h3FF))
            line_count <= line_count + 10'd1;
      end
   end

endmodule

// File: tb/tb_pal_sync_decoder.sv
// tb/tb_pal_sync_decoder.sv - scoreboard bench for pal_sync_decoder
module tb_pal_sync_decoder;

   logic       clk50 = 1'b0;
   logic       rst_n;
   logic [7:0] adc_data;
   logic       hs_pulse;
   logic       vs_pulse;
   logic       field;
   logic [9:0] line_count;
   logic       locked;

   int edge_n = 0;
   int checks = 0;
   int errors = 0;
   int exp_lc = 0;
   logic exp_field = 1'b0;
   int e0 = 0;

   typedef struct {
      int         at_edge;
      logic       is_vs;
      logic [9:0] lc;
      logic       lk;
      logic       fld;
   } exp_t;

   exp_t exp_q[$];

   pal_sync_decoder dut (
      .clk50      (clk50),
      .rst_n      (rst_n),
      .adc_data   (adc_data),
      .hs_pulse   (hs_pulse),
      .vs_pulse   (vs_pulse),
      .field      (field),
      .line_count (line_count),
      .locked     (locked)
   );

   always #10 clk50 = ~clk50;

   always @(posedge clk50) edge_n <= edge_n + 1;

   task automatic drive(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         adc_data = v;
         @(posedge clk50);
         #1;
      end
   endtask

   task automatic push_h(input logic lk);
      exp_t e;
      exp_lc    = (exp_lc >= 1023) ? 1023 : exp_lc + 1;
      e.at_edge = edge_n + 2;
      e.is_vs   = 1'b0;
      e.lc      = 10'(exp_lc);
      e.lk      = lk;
      e.fld     = exp_field;
      exp_q.push_back(e);
   endtask

   task automatic push_vs();
      exp_t e;
      exp_lc    = 0;
      e.at_edge = edge_n + 2;
      e.is_vs   = 1'b1;
      e.lc      = 10'd0;
      e.lk      = 1'b1;
      e.fld     = exp_field;
      exp_q.push_back(e);
   endtask

   task automatic h_line(input logic lk, input int body);
      drive(8'd0, 235);
      push_h(lk);
      drive(8'd128, body);
   endtask

   task automatic check1(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic wait_edge(input int target);
      while (edge_n < target) @(negedge clk50);
   endtask

   // Monitor: every strobe pops one expected record
   initial begin
      exp_t e;
      forever begin
         @(negedge clk50);
         if (hs_pulse || vs_pulse) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse edge=%0d hs=%0b vs=%0b", edge_n, hs_pulse, vs_pulse);
            end else begin
               e = exp_q.pop_front();
               if (edge_n != e.at_edge || vs_pulse != e.is_vs || hs_pulse == e.is_vs ||
                   line_count != e.lc || locked != e.lk || field != e.fld) begin
                  errors++;
                  $display("FAIL pulse actual edge=%0d hs=%0b vs=%0b lc=%0d locked=%0b field=%0b required edge=%0d vs=%0b lc=%0d locked=%0b field=%0b",
                           edge_n, hs_pulse, vs_pulse, line_count, locked, field,
                           e.at_edge, e.is_vs, e.lc, e.lk, e.fld);
               end
            end
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      adc_data = 8'd128;
      repeat (3) @(posedge clk50);
      @(negedge clk50);
      check1("reset_hs", int'(hs_pulse), 0);
      check1("reset_vs", int'(vs_pulse), 0);
      check1("reset_field", int'(field), 0);
      check1("reset_line_count", int'(line_count), 0);
      check1("reset_locked", int'(locked), 0);
      @(posedge clk50);
      #1;
      rst_n = 1'b1;
      drive(8'd128, 10);

      // Ten nominal lines; lock arrives with the ninth hsync, tenth carries a glitch
      for (int i = 1; i <= 9; i++) h_line(i >= 9, 2965);
      h_line(1'b1, 1000);
      drive(8'd0, 50);
      drive(8'd128, 1915);
      check1("glitch_locked", int'(locked), 1);
      check1("glitch_line_count", int'(line_count), 10);

      // Vertical interval, EQ->H gap 1600 gives field 1
      drive(8'd0, 117);
      drive(8'd128, 1483);
      for (int k = 0; k < 5; k++) begin
         drive(8'd0, 1365);
         if (k == 2) push_vs();
         drive(8'd128, 235);
      end
      drive(8'd0, 117);
      drive(8'd128, 1365);
      exp_field = 1'b1;
      h_line(1'b1, 2965);
      check1("field_one", int'(field), 1);

      // Second vertical interval, EQ->H gap 3200 gives field 0
      for (int k = 0; k < 3; k++) begin
         drive(8'd0, 1365);
         if (k == 2) push_vs();
         drive(8'd128, 235);
      end
      drive(8'd0, 117);
      drive(8'd128, 2965);
      exp_field = 1'b0;
      h_line(1'b1, 2965);
      check1("field_zero", int'(field), 0);

      // Reset in the middle of the third broad pulse
      for (int k = 0; k < 2; k++) begin
         drive(8'd0, 1365);
         drive(8'd128, 235);
      end
      drive(8'd0, 700);
      check1("pre_reset_locked", int'(locked), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check1("async_reset_hs", int'(hs_pulse), 0);
      check1("async_reset_vs", int'(vs_pulse), 0);
      check1("async_reset_field", int'(field), 0);
      check1("async_reset_line_count", int'(line_count), 0);
      check1("async_reset_locked", int'(locked), 0);
      repeat (3) @(posedge clk50);
      #1;
      rst_n     = 1'b1;
      exp_lc    = 0;
      exp_field = 1'b0;
      drive(8'd0, 665);
      drive(8'd128, 2000);

      // Relock: first tip sits at 45 for its second part, hysteresis keeps it one H pulse
      drive(8'd0, 100);
      drive(8'd45, 135);
      push_h(1'b0);
      drive(8'd128, 2965);
      for (int i = 2; i <= 8; i++) h_line(1'b0, 2965);
      drive(8'd0, 235);
      push_h(1'b1);
      e0 = edge_n;
      drive(8'd128, 1);

      // Loss of sync: flywheel line, then unlock on silence
      wait_edge(e0 + 3266);
      check1("flywheel_before", int'(line_count), 9);
      wait_edge(e0 + 3267);
      check1("flywheel_after", int'(line_count), 10);
      wait_edge(e0 + 6402);
      check1("silence_hold_locked", int'(locked), 1);
      wait_edge(e0 + 6403);
      check1("silence_unlock", int'(locked), 0);
      wait_edge(e0 + 6700);
      check1("flywheel_stopped", int'(line_count), 10);
      check1("still_unlocked", int'(locked), 0);
      check1("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
